// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the MOV/MOC read handshake to the RAM, tracks the PC,
// and holds each fetched word in a single-entry valid/ready slot for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        MOV,
    output logic        Enable,
    output logic        ReadWrite,
    output logic [31:0] Address,
    input  logic [31:0] DataOut,
    input  logic        MOC,
    output logic [31:0] IR,
    output logic [31:0] PC_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_error
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERROR} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic             mov_q, mov_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            pc_out_q  <= '0;
            mov_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            pc_out_q  <= pc_out_d;
            mov_q     <= mov_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        pc_out_d  = pc_out_q;
        mov_d     = mov_q;
        valid_d   = valid_q;
        err_d     = err_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;

        // Decode consuming the held word; a load in WAIT overrides this below.
        if (state_q != S_ERROR && valid_q && ir_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (discard_q && MOC) begin
                    discard_d = 1'b0;
                end
                if ((!valid_q || ir_ready) && !discard_q) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mov_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (MOC) begin
                    ir_d     = DataOut;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    valid_d  = 1'b1;
                    mov_d    = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        mov_d   = 1'b0;
                        state_d = S_ERROR;
                    end
                end
            end
            default: ;
        endcase

        // Redirect wins over everything; a read still outstanding must have its reply dropped.
        if (branch_taken && state_q != S_ERROR) begin
            pc_d     = branch_target & ~32'h3;
            ir_d     = ir_q;
            pc_out_d = pc_out_q;
            valid_d  = 1'b0;
            mov_d    = 1'b0;
            err_d    = err_q;
            state_d  = S_IDLE;
            if (state_q == S_WAIT && !MOC) begin
                discard_d = 1'b1;
            end
        end
    end

    assign MOV         = mov_q;
    assign Enable      = mov_q;
    assign ReadWrite   = 1'b1;
    assign Address     = pc_q;
    assign IR          = ir_q;
    assign PC_out      = pc_out_q;
    assign ir_valid    = valid_q;
    assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetches, back-pressure, branch discard,
// timeout into the error state, and recovery through reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MOV, Enable, ReadWrite;
    logic [31:0] Address;
    logic [31:0] DataOut;
    logic        MOC;
    logic [31:0] IR, PC_out;
    logic        ir_valid, ir_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:4];

    fetch_unit #(.RESET_PC(32'd0), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .MOV(MOV), .Enable(Enable), .ReadWrite(ReadWrite),
        .Address(Address), .DataOut(DataOut), .MOC(MOC), .IR(IR), .PC_out(PC_out),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .branch_taken(branch_taken),
        .branch_target(branch_target), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " MOV"}, {31'd0, MOV}, 32'd0);
        chk({tag, " Enable"}, {31'd0, Enable}, 32'd0);
        chk({tag, " ReadWrite"}, {31'd0, ReadWrite}, 32'd1);
        chk({tag, " Address"}, Address, 32'd0);
        chk({tag, " IR"}, IR, 32'd0);
        chk({tag, " PC_out"}, PC_out, 32'd0);
        chk({tag, " ir_valid"}, {31'd0, ir_valid}, 32'd0);
        chk({tag, " fetch_error"}, {31'd0, fetch_error}, 32'd0);
    endtask

    // Answer the outstanding read with MOC for one edge and check the loaded word.
    task automatic respond(input logic [31:0] data, input logic [31:0] addr);
        MOC = 1'b1;
        DataOut = data;
        tick();
        chk("load IR", IR, data);
        chk("load PC_out", PC_out, addr);
        chk("load ir_valid", {31'd0, ir_valid}, 32'd1);
        chk("load MOV low", {31'd0, MOV}, 32'd0);
        chk("load ReadWrite", {31'd0, ReadWrite}, 32'd1);
        $display("fetch addr=%h data=%h ir_valid=%0d", PC_out, IR, ir_valid);
        MOC = 1'b0;
        DataOut = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'hE7D12000;
        mem[1] = 32'h11223344;
        mem[2] = 32'h55667788;
        mem[3] = 32'h99AABBCC;
        mem[4] = 32'hCAFEF00D;

        reset = 1'b1;
        MOC = 1'b0;
        DataOut = 32'h0;
        ir_ready = 1'b1;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        tick();
        tick();
        chk_reset_state("reset");

        // Edge 0 with reset low: IDLE->REQ, MOV still low; edge 1: request at RESET_PC.
        reset = 1'b0;
        tick();
        chk("edge0 MOV", {31'd0, MOV}, 32'd0);
        tick();

        for (int i = 0; i < 4; i++) begin
            chk("seq MOV high", {31'd0, MOV}, 32'd1);
            chk("seq Enable", {31'd0, Enable}, 32'd1);
            chk("seq Address", Address, 32'(i * 4));
            respond(mem[i], 32'(i * 4));
            tick();
            chk("gap MOV low", {31'd0, MOV}, 32'd0);
            chk("gap ir_valid consumed", {31'd0, ir_valid}, 32'd0);
            tick();
        end

        // Back-pressure: decode stalls for 5 cycles after the word at 16.
        chk("bp MOV high", {31'd0, MOV}, 32'd1);
        chk("bp Address", Address, 32'd16);
        ir_ready = 1'b0;
        respond(mem[4], 32'd16);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold MOV", {31'd0, MOV}, 32'd0);
            chk("bp hold IR", IR, mem[4]);
            chk("bp hold valid", {31'd0, ir_valid}, 32'd1);
        end
        ir_ready = 1'b1;
        tick();
        chk("bp release valid", {31'd0, ir_valid}, 32'd0);
        chk("bp release MOV", {31'd0, MOV}, 32'd0);
        tick();
        chk("bp next MOV", {31'd0, MOV}, 32'd1);
        chk("bp next Address", Address, 32'd20);

        // Branch while waiting; the reply two cycles later must be dropped.
        branch_taken = 1'b1;
        branch_target = 32'h29;
        tick();
        branch_taken = 1'b0;
        chk("br MOV low", {31'd0, MOV}, 32'd0);
        chk("br valid", {31'd0, ir_valid}, 32'd0);
        tick();
        chk("br discard wait MOV", {31'd0, MOV}, 32'd0);
        MOC = 1'b1;
        DataOut = 32'hDEADBEEF;
        tick();
        MOC = 1'b0;
        chk("br stale valid", {31'd0, ir_valid}, 32'd0);
        chk("br stale IR", IR, mem[4]);
        $display("branch discard IR=%h ir_valid=%0d", IR, ir_valid);
        tick();
        chk("br req MOV", {31'd0, MOV}, 32'd0);
        tick();
        chk("br target MOV", {31'd0, MOV}, 32'd1);
        chk("br target Address", Address, 32'h28);

        // Branch and MOC together: data dropped, no pending discard.
        branch_taken = 1'b1;
        branch_target = 32'h100;
        MOC = 1'b1;
        DataOut = 32'hBADC0DE5;
        tick();
        branch_taken = 1'b0;
        MOC = 1'b0;
        chk("brmoc valid", {31'd0, ir_valid}, 32'd0);
        chk("brmoc IR", IR, mem[4]);
        chk("brmoc MOV", {31'd0, MOV}, 32'd0);
        tick();
        chk("brmoc gap MOV", {31'd0, MOV}, 32'd0);
        tick();
        chk("brmoc target MOV", {31'd0, MOV}, 32'd1);
        chk("brmoc target Address", Address, 32'h100);
        respond(32'h0A0B0C0D, 32'h100);
        tick();
        tick();
        chk("to MOV high", {31'd0, MOV}, 32'd1);
        chk("to Address", Address, 32'h104);

        // Timeout: MOC never arrives; error exactly 15 edges after MOV rose.
        for (int i = 0; i < 14; i++) tick();
        chk("to not yet error", {31'd0, fetch_error}, 32'd0);
        chk("to not yet MOV", {31'd0, MOV}, 32'd1);
        tick();
        chk("to error", {31'd0, fetch_error}, 32'd1);
        chk("to MOV low", {31'd0, MOV}, 32'd0);
        $display("timeout fetch_error=%0d MOV=%0d", fetch_error, MOV);
        MOC = 1'b1;
        DataOut = 32'h12345678;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        tick();
        tick();
        branch_taken = 1'b0;
        chk("err frozen error", {31'd0, fetch_error}, 32'd1);
        chk("err frozen MOV", {31'd0, MOV}, 32'd0);
        chk("err frozen Address", Address, 32'h104);
        chk("err frozen valid", {31'd0, ir_valid}, 32'd0);
        chk("err frozen IR", IR, 32'h0A0B0C0D);

        // Reset exits ERROR; a MOC lingering across reset is ignored.
        reset = 1'b1;
        tick();
        chk_reset_state("rerst");
        reset = 1'b0;
        tick();
        chk("rerst late MOC valid", {31'd0, ir_valid}, 32'd0);
        chk("rerst late MOC IR", IR, 32'd0);
        MOC = 1'b0;
        tick();
        chk("rerst MOV", {31'd0, MOV}, 32'd1);
        chk("rerst Address", Address, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage in front of the `ram256x32` memory. It drives the MOV/MOC read handshake, keeps the PC, and presents each fetched 32-bit instruction word to decode through a one-entry valid/ready output register. It also handles branch redirects and a memory-response timeout.

## Interface
Parameters:
- RESET_PC, 32'd0, byte address fetched first after reset
- TIMEOUT, 15, maximum cycles spent in WAIT without MOC before error

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- MOV  out  1  memory operation valid, to RAM
- Enable  out  1  RAM enable; equal to MOV
- ReadWrite  out  1  constant 1 (read); this block never writes
- Address  out  32  byte address of the current fetch (PC)
- DataOut  in  32  RAM read data, sampled when MOC=1
- MOC  in  1  memory operation complete, from RAM
- IR  out  32  fetched instruction word
- PC_out  out  32  byte address of the word in IR
- ir_valid  out  1  IR holds an unconsumed instruction
- ir_ready  in  1  decode accepts IR this cycle
- branch_taken  in  1  single-cycle redirect request
- branch_target  in  32  redirect byte address
- fetch_error  out  1  sticky flag set by a timeout

## Operation
- Reset values: state=IDLE, PC=RESET_PC, MOV=0, Enable=0, ReadWrite=1, Address=RESET_PC, IR=0, PC_out=0, ir_valid=0, fetch_error=0, timeout counter=0.
- States are IDLE, REQ, WAIT and ERROR.
- IDLE: go to REQ when the output slot is free (!ir_valid || ir_ready).
- REQ: MOV=1, Address=PC, counter cleared, then go to WAIT.
- WAIT:
  - MOV stays 1 and Address stays stable.
  - The counter increments every cycle MOC=0.
  - On MOC=1: IR<=DataOut, PC_out<=PC, PC<=PC+4 (mod 2^32), ir_valid<=1, MOV<=0, then go to IDLE.
- Handshake: ir_valid clears when ir_valid && ir_ready and no new word loads in the same cycle. The slot is single-entry, so a new fetch never starts while an unaccepted word is held.
- Branch (highest priority, in any state except ERROR):
  - PC<=branch_target with bits [1:0] forced to 0.
  - ir_valid<=0 and MOV<=0, then go to IDLE.
  - A MOC in the same cycle is ignored and its data discarded.
  - If a read was in flight and MOC has not yet arrived, set a discard flag. The next MOC is dropped and clears the flag; no REQ is issued until then, so stale data never reaches IR.
- Timeout: if the counter reaches TIMEOUT in WAIT, set fetch_error=1, MOV=0, and go to ERROR.
- ERROR: all outputs are frozen and branch and MOC are ignored. Only reset exits this state.
- Reset mid-transaction: on the next edge every output returns to its reset value, and any late MOC after reset is ignored while in IDLE.

## Timing
- Reset deasserted at edge 0: MOV=1 with Address=RESET_PC from edge 1.
- MOC=1 sampled at edge k: IR and ir_valid are updated and MOV=0 from edge k.
- Next MOV=1 no earlier than edge k+2, so MOV is low for at least one cycle between requests.
- Best-case throughput is one instruction per 3 cycles with single-cycle MOC and ir_ready held at 1.
- Branch sampled at edge b: MOV=1 with Address=target no earlier than edge b+2 (later if a discard is pending).
- fetch_error rises at the edge where the counter reaches TIMEOUT: TIMEOUT cycles after MOV rose with MOC held low.

## Test plan
- Reset, then RAM holds 0xE7D12000 at addresses 0–3, MOC one cycle after MOV, ir_ready=1 -> IR=0xE7D12000, PC_out=0, next Address=4, MOV low for 1 cycle between fetches.
- Sequential run over addresses 0, 4, 8, 12 -> PC_out sequence 0, 4, 8, 12; ir_valid pulses each time; ReadWrite stays 1.
- ir_ready=0 for 5 cycles after the first word -> IR held stable, MOV stays 0, next fetch starts only after ir_ready=1.
- branch_taken with target 0x29 while in WAIT, MOC arrives 2 cycles later -> that word is discarded, ir_valid stays 0, next Address=0x28.
- branch_taken and MOC in the same cycle -> data discarded, next fetch at the target.
- MOC held at 0 -> fetch_error=1 exactly 15 cycles after MOV rose, MOV=0; later MOC and branch ignored; reset restores all outputs to reset values.
